// File: rtl/dmem_responder_if.sv
// Data-memory bus between the MEM stage and dmem_responder.
//   addr    : byte address from the EX/MEM ALU-result register
//   SW, LW  : registered store / load strobes
//   Databus : shared 32-bit bidirectional data bus. The processor drives it
//             on stores. The memory drives it only during a valid load.
interface dmem_responder_if;
    logic [31:0] addr;
    logic        SW;
    logic        LW;
    wire  [31:0] Databus;

    modport master (output addr, output SW, output LW, inout Databus);
    modport slave  (input addr, input SW, input LW, inout Databus);
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering MEM-stage load/store traffic.
// A load drives the addressed word onto Databus combinationally in the same
// cycle, so there is no load latency. A store commits at the rising edge.
// The first invalid access after reset is latched into err / err_addr.
// Invalid accesses are LW and SW together, or a misaligned address.
//
// Ports:
//   clk      : system clock (rising edge)
//   rst      : asynchronous active-high reset
//   bus      : dmem_responder_if.slave (addr, SW, LW, Databus)
//   err      : sticky error flag
//   err_addr : address of the first erroring access
//   ld_cnt   : saturating count of valid loads (0 unless DMEM_STATS_EN)
//   st_cnt   : saturating count of valid stores (0 unless DMEM_STATS_EN)
//
// Build option: define DMEM_STATS_EN to include the load/store counters.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_responder_if.slave         bus,
    output logic                    err,
    output logic [31:0]             err_addr,
    output logic [15:0]             ld_cnt,
    output logic [15:0]             st_cnt
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        CLEAN,
        LATCHED
    } err_state_t;

    err_state_t err_state, err_state_next;

    logic [31:0]           mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  aligned;
    logic                  ld_ok;
    logic                  st_ok;
    logic                  bad;
    logic                  oe;

    // Upper address bits are ignored, so addresses alias across the map.
    assign idx     = bus.addr[DEPTH_LOG2+1:2];
    assign aligned = (bus.addr[1:0] == 2'b00);
    assign ld_ok   = bus.LW & ~bus.SW & aligned;
    assign st_ok   = bus.SW & ~bus.LW & aligned;
    assign bad     = (bus.LW | bus.SW) & ~ld_ok & ~st_ok;

    // rst gates the drive enable directly, so the bus is released as soon
    // as reset asserts rather than at the next edge.
    assign oe          = ld_ok & ~rst;
    assign bus.Databus = oe ? mem[idx] : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (st_ok) begin
            mem[idx] <= bus.Databus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_state <= CLEAN;
            err_addr  <= '0;
        end else begin
            err_state <= err_state_next;
            if (err_state == CLEAN && bad) begin
                err_addr <= bus.addr;
            end
        end
    end

    always_comb begin
        err_state_next = err_state;
        err            = 1'b0;
        case (err_state)
            CLEAN: begin
                if (bad) begin
                    err_state_next = LATCHED;
                end
            end
            LATCHED: begin
                err = 1'b1;
            end
            default: begin
                err_state_next = CLEAN;
            end
        endcase
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (ld_ok && ld_cnt != '1) begin
                ld_cnt <= ld_cnt + 16'd1;
            end
            if (st_ok && st_cnt != '1) begin
                st_cnt <= st_cnt + 16'd1;
            end
        end
    end
`else
    always_comb begin
        ld_cnt = '0;
        st_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int unsigned DEPTH_LOG2 = 6;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
`ifdef DMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    logic        tb_oe   = 1'b0;
    logic [31:0] tb_data = '0;

    dmem_responder_if bus ();

    assign bus.Databus = tb_oe ? tb_data : 'z;

    dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err      (err),
        .err_addr (err_addr),
        .ld_cnt   (ld_cnt),
        .st_cnt   (st_cnt)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_mem [DEPTH];
    bit          m_err;
    logic [31:0] m_err_addr;
    int unsigned m_ld;
    int unsigned m_st;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_err      = 1'b0;
        m_err_addr = '0;
        m_ld       = 0;
        m_st       = 0;
    endtask

    task automatic check_regs();
        check("err", {31'd0, err}, {31'd0, m_err});
        check("err_addr", err_addr, m_err_addr);
        check("ld_cnt", {16'd0, ld_cnt}, STATS ? m_ld : 32'd0);
        check("st_cnt", {16'd0, st_cnt}, STATS ? m_st : 32'd0);
    endtask

    // One bus cycle: drive at negedge, check mid-cycle, update model at posedge.
    task automatic step(input bit lw, input bit sw, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] probe;
        bit          aligned, ld_ok, st_ok, bad;
        int unsigned idx;
        @(negedge clk);
        bus.LW   = lw;
        bus.SW   = sw;
        bus.addr = a;
        aligned  = (a % 4) == 0;
        ld_ok    = lw && !sw && aligned;
        st_ok    = sw && !lw && aligned;
        bad      = (lw || sw) && !ld_ok && !st_ok;
        idx      = (a / 4) % DEPTH;
        probe    = $urandom;
        if (sw) begin
            tb_oe   = 1'b1;
            tb_data = d;
        end else if (ld_ok) begin
            tb_oe = 1'b0;
        end else begin
            tb_oe   = 1'b1;
            tb_data = probe;
        end
        #2;
        if (ld_ok) check("load_data", bus.Databus, m_mem[idx]);
        else       check("bus_released", bus.Databus, sw ? d : probe);
        check_regs();
        @(posedge clk);
        if (st_ok) begin
            m_mem[idx] = d;
            if (m_st < 65535) m_st++;
        end
        if (ld_ok && m_ld < 65535) m_ld++;
        if (bad && !m_err) begin
            m_err      = 1'b1;
            m_err_addr = a;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        bus.LW = 1'b0;
        bus.SW = 1'b0;
        tb_oe  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_regs();
    endtask

    initial begin
        bus.addr = '0;
        bus.LW   = 1'b0;
        bus.SW   = 1'b0;
        model_reset();
        do_reset();

        // Load after reset returns zero, then bus released on idle
        step(1, 0, 32'h10, '0);
        step(0, 0, 32'h10, '0);
        // Store then load same word
        step(0, 1, 32'h24, 32'hDEADBEEF);
        step(1, 0, 32'h24, '0);
        // Aliasing: 0x104 maps to the same word as 0x04
        step(0, 1, 32'h04, 32'h11111111);
        step(1, 0, 32'h104, '0);
        // Back-to-back loads and load followed by store
        step(1, 0, 32'h04, '0);
        step(1, 0, 32'h24, '0);
        step(0, 1, 32'h28, 32'hCAFEF00D);
        step(1, 0, 32'h28, '0);

        // Reset asserted during a load releases the bus without a clock
        @(negedge clk);
        bus.LW   = 1'b1;
        bus.SW   = 1'b0;
        bus.addr = 32'h24;
        tb_oe    = 1'b0;
        #2;
        check("pre_rst_load", bus.Databus, m_mem[9]);
        rst     = 1'b1;
        tb_oe   = 1'b1;
        tb_data = '0;
        #1;
        check("rst_release", bus.Databus, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.LW = 1'b0;
        rst    = 1'b0;
        tb_oe  = 1'b0;
        model_reset();
        step(1, 0, 32'h24, '0);

        // Store in the same cycle as reset is discarded
        @(negedge clk);
        bus.SW   = 1'b1;
        bus.LW   = 1'b0;
        bus.addr = 32'h08;
        tb_oe    = 1'b1;
        tb_data  = 32'h5;
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.SW = 1'b0;
        tb_oe  = 1'b0;
        rst    = 1'b0;
        model_reset();
        step(1, 0, 32'h08, '0);

        // Errors: first one latched, later ones ignored, no write on LW+SW
        step(1, 0, 32'h22, '0);
        step(0, 0, 32'h0, '0);
        step(1, 1, 32'h30, 32'h77777777);
        step(1, 0, 32'h30, '0);
        step(0, 1, 32'h31, 32'h12345678);
        step(1, 0, 32'h30, '0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 15) << 2) | (($urandom & 32'hFFFFFF) << 8);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (n == 1500) do_reset();
            step(op inside {[1:4]} || op == 9, op inside {[5:8]} || op == 9, a, $urandom);
        end

        // Counter saturation
        do_reset();
        if (STATS) begin
            for (int n = 0; n < 65534; n++) step(1, 0, 32'h0, '0);
            check("ld_cnt_fffe", {16'd0, ld_cnt}, 32'h0000FFFE);
            for (int n = 0; n < 3; n++) step(1, 0, 32'h4, '0);
            step(0, 0, 32'h0, '0);
            check("ld_cnt_sat", {16'd0, ld_cnt}, 32'h0000FFFF);
        end else begin
            for (int n = 0; n < 20; n++) step(1, 0, 32'h0, '0);
            step(0, 1, 32'h0, 32'h1);
            step(0, 0, 32'h0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
